// File: rtl/mmcm_drp_reconfig_pkg.sv
// rtl/mmcm_drp_reconfig_pkg.sv - shared field offsets, state enum and default timeouts
package mmcm_drp_reconfig_pkg;

  localparam int ADDR_MSB = 38;
  localparam int ADDR_LSB = 32;
  localparam int MASK_MSB = 31;
  localparam int MASK_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam int DEF_NUM_ENTRIES  = 23;
  localparam int DEF_DRDY_TIMEOUT = 255;
  localparam int DEF_LOCK_TIMEOUT = 65535;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_FETCH,
    S_FETCH_WAIT,
    S_READ,
    S_READ_WAIT,
    S_WRITE,
    S_WRITE_WAIT,
    S_RELEASE,
    S_WAIT_LOCK,
    S_FINISH
  } state_e;

endpackage

// File: rtl/mmcm_drp_reconfig_sync_bit.sv
// rtl/mmcm_drp_reconfig_sync_bit.sv - two-flop synchronizer for a single asynchronous bit
module mmcm_drp_reconfig_sync_bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// rtl/mmcm_drp_reconfig.sv - applies a BRAM-held reconfiguration table to the MMCM via DRP
module mmcm_drp_reconfig
  import mmcm_drp_reconfig_pkg::*;
#(
  parameter int NUM_ENTRIES  = DEF_NUM_ENTRIES,
  parameter int DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [4:0]  tbl_idx_o,
  input  logic [38:0] tbl_data_i,
  output logic [6:0]  daddr_o,
  output logic [15:0] di_o,
  output logic        den_o,
  output logic        dwe_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic        mmcm_rst_o,
  input  logic        locked_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam logic [4:0]  LAST_IDX = 5'(NUM_ENTRIES - 1);
  localparam logic [15:0] DRDY_TO  = 16'(DRDY_TIMEOUT);
  localparam logic [15:0] LOCK_TO  = 16'(LOCK_TIMEOUT);

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [6:0]  addr_q;
  logic [15:0] mask_q;
  logic [15:0] data_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [6:0]  daddr_q;
  logic [15:0] di_q;
  logic        den_q;
  logic        dwe_q;
  logic        mmcm_rst_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic        locked_sync;

  mmcm_drp_reconfig_sync_bit u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (locked_i),
    .q_o   (locked_sync)
  );

  // Saturating wait counter: a stuck DRDY/LOCKED must never wrap back under the limit.
  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      daddr_q    <= '0;
      di_q       <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      mmcm_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      den_q  <= 1'b0;
      dwe_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            idx_q     <= '0;
            state_q   <= S_ASSERT_RST;
          end
        end
        S_ASSERT_RST: begin
          mmcm_rst_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        // idx_q doubles as the BRAM address, so it is already stable throughout FETCH.
        S_FETCH: begin
          cnt_q   <= '0;
          state_q <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          addr_q  <= tbl_data_i[ADDR_MSB:ADDR_LSB];
          mask_q  <= tbl_data_i[MASK_MSB:MASK_LSB];
          data_q  <= tbl_data_i[DATA_MSB:DATA_LSB];
          state_q <= S_READ;
        end
        S_READ: begin
          daddr_q <= addr_q;
          den_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (drdy_i) begin
            di_q    <= (do_i & mask_q) | data_q;
            state_q <= S_WRITE;
          end else if (cnt_q == DRDY_TO) begin
            timeout_q  <= 1'b1;
            mmcm_rst_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WRITE: begin
          den_q   <= 1'b1;
          dwe_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WRITE_WAIT;
        end
        S_WRITE_WAIT: begin
          if (drdy_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_RELEASE;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= S_FETCH;
            end
          end else if (cnt_q == DRDY_TO) begin
            timeout_q  <= 1'b1;
            mmcm_rst_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RELEASE: begin
          mmcm_rst_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_sync) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (cnt_q == LOCK_TO) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // DONE is visible here while BUSY is still high, so a START on the DONE cycle is ignored.
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tbl_idx_o  = idx_q;
  assign daddr_o    = daddr_q;
  assign di_o       = di_q;
  assign den_o      = den_q;
  assign dwe_o      = dwe_q;
  assign mmcm_rst_o = mmcm_rst_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;

endmodule
